// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column/row from an incoming VGA sync pair, tracks
// lock against nominal timing and counts sync mismatches.
// Optional macro VGA_RX_PIXEL_DECODE_EN enables the 9-bit colour -> 2-bit
// sprite pixel decoder; without it o_Pixel/o_Pixel_Valid stay 0.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FPORCH    = 16,
  parameter int unsigned H_PULSE     = 96,
  parameter int unsigned H_MAX       = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FPORCH    = 10,
  parameter int unsigned V_MAX       = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [2:0] i_Red,
  input  logic [2:0] i_Grn,
  input  logic [2:0] i_Blu,
  output logic [9:0] o_Column,
  output logic [9:0] o_Row,
  output logic       o_Active,
  output logic [1:0] o_Pixel,
  output logic       o_Pixel_Valid,
  output logic       o_Locked,
  output logic       o_Frame_Start,
  output logic       o_Timing_Err,
  output logic [7:0] o_Err_Count
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = 8;
  localparam int unsigned EW = 8;

  localparam logic [CW-1:0] HS_COL  = CW'(H_ACTIVE + H_FPORCH);
  localparam logic [CW-1:0] VS_ROW  = CW'(V_ACTIVE + V_FPORCH - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_MAX - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_MAX - 1);
  localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] PULSE_W = CW'(H_PULSE);
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [CW-1:0] hs_width_q, hs_width_d;
  logic [GW-1:0] good_q, good_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [CW-1:0] out_row_q, out_row_d;
  logic          active_q, active_d;
  logic          locked_q, locked_d;
  logic          frame_start_q, frame_start_d;
  logic          timing_err_q, timing_err_d;

  logic hs_fall, hs_rise, vs_fall, col_wrap, mismatch;

  assign hs_fall = hs_q & ~i_HSync;
  assign hs_rise = ~hs_q & i_HSync;
  assign vs_fall = vs_q & ~i_VSync;

  // Counters, sync checks, lock FSM and registered status outputs.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    hs_d          = i_HSync;
    vs_d          = i_VSync;
    hs_width_d    = hs_width_q;
    good_d        = good_q;
    err_cnt_d     = err_cnt_q;
    out_col_d     = col_q;
    out_row_d     = row_q;
    active_d      = 1'b0;
    locked_d      = 1'b0;
    frame_start_d = 1'b0;
    timing_err_d  = 1'b0;
    col_wrap      = 1'b0;
    mismatch      = 1'b0;

    // Free-running position, resynchronised on sync falls.
    if (hs_fall) begin
      col_d = HS_COL + CW'(1);
    end else if (col_q == H_LAST) begin
      col_d    = '0;
      col_wrap = 1'b1;
    end else begin
      col_d = col_q + CW'(1);
    end

    if (vs_fall) begin
      row_d = VS_ROW;
    end else if (col_wrap) begin
      row_d = (row_q == V_LAST) ? '0 : row_q + CW'(1);
    end

    // Low-width of hsync counts the current low sample too.
    if (hs_fall) begin
      hs_width_d = CW'(1);
    end else if (!i_HSync && (hs_width_q != {CW{1'b1}})) begin
      hs_width_d = hs_width_q + CW'(1);
    end

    mismatch = (hs_fall && (col_q != HS_COL)) ||
               (vs_fall && (row_q != VS_ROW)) ||
               (hs_rise && (hs_width_q != PULSE_W));

    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = TRACK;
          good_d  = GW'(1);
        end
      end
      TRACK: begin
        if (mismatch) begin
          good_d = '0;
        end else if (vs_fall) begin
          if ((good_q + GW'(1)) >= LOCK_N) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d      = TRACK;
          good_d       = '0;
          timing_err_d = 1'b1;
          if (err_cnt_q != {EW{1'b1}}) err_cnt_d = err_cnt_q + EW'(1);
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d      = (state_d == LOCKED);
    active_d      = locked_d && (col_q < H_VIS) && (row_q < V_VIS);
    frame_start_d = locked_d && (col_q == '0) && (row_q == '0);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q       <= SEARCH;
      col_q         <= '0;
      row_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hs_width_q    <= '0;
      good_q        <= '0;
      err_cnt_q     <= '0;
      out_col_q     <= '0;
      out_row_q     <= '0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hs_width_q    <= hs_width_d;
      good_q        <= good_d;
      err_cnt_q     <= err_cnt_d;
      out_col_q     <= out_col_d;
      out_row_q     <= out_row_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

`ifdef VGA_RX_PIXEL_DECODE_EN
  logic [1:0] pixel_q, pixel_d;
  logic       pixel_valid_q, pixel_valid_d;
  logic [8:0] rgb;

  assign rgb = {i_Red, i_Grn, i_Blu};

  // Map the four sprite palette colours; anything else is not a sprite pixel.
  always_comb begin
    pixel_d       = 2'd0;
    pixel_valid_d = 1'b0;
    if (active_d) begin
      case (rgb)
        9'b000000000: begin pixel_d = 2'd0; pixel_valid_d = 1'b1; end
        9'b111111100: begin pixel_d = 2'd1; pixel_valid_d = 1'b1; end
        9'b111000000: begin pixel_d = 2'd2; pixel_valid_d = 1'b1; end
        9'b000111000: begin pixel_d = 2'd3; pixel_valid_d = 1'b1; end
        default:      begin pixel_d = 2'd0; pixel_valid_d = 1'b0; end
      endcase
    end
  end

  // Pixel output register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      pixel_q       <= 2'd0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign o_Pixel       = pixel_q;
  assign o_Pixel_Valid = pixel_valid_q;
`else
  logic unused_colour;
  assign unused_colour = ^{i_Red, i_Grn, i_Blu};
  assign o_Pixel       = 2'd0;
  assign o_Pixel_Valid = 1'b0;
`endif

  assign o_Column      = out_col_q;
  assign o_Row         = out_row_q;
  assign o_Active      = active_q;
  assign o_Locked      = locked_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Timing_Err  = timing_err_q;
  assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 24x12 timing
// (16x8 visible, hsync low at columns 18..21, vsync low for row 9).
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HP = 4, HM = 24;
  localparam int VA = 8, VF = 2, VM = 12, LF = 2;
  localparam int HS_COL = HA + HF;
  localparam int VS_ROW = VA + VF - 1;
  localparam int FRAME  = HM * VM;
`ifdef VGA_RX_PIXEL_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam int F_COL = 0, F_ROW = 1, F_ACT = 2, F_PIX = 3, F_VAL = 4;
  localparam int F_LCK = 5, F_FS = 6, F_TE = 7, F_ERR = 8;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L, i_HSync, i_VSync;
  logic [2:0] i_Red, i_Grn, i_Blu;
  logic [9:0] o_Column, o_Row;
  logic       o_Active, o_Pixel_Valid, o_Locked, o_Frame_Start, o_Timing_Err;
  logic [1:0] o_Pixel;
  logic [7:0] o_Err_Count;

  typedef struct {
    string       tag;
    int          field;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sc = 0, sr = 0;
  int   fs_cnt = 0, te_cnt = 0;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FPORCH(HF), .H_PULSE(HP), .H_MAX(HM),
    .V_ACTIVE(VA), .V_FPORCH(VF), .V_MAX(VM), .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_Column(o_Column), .o_Row(o_Row), .o_Active(o_Active),
    .o_Pixel(o_Pixel), .o_Pixel_Valid(o_Pixel_Valid), .o_Locked(o_Locked),
    .o_Frame_Start(o_Frame_Start), .o_Timing_Err(o_Timing_Err),
    .o_Err_Count(o_Err_Count)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [31:0] obs(input int f);
    case (f)
      F_COL:   return 32'(o_Column);
      F_ROW:   return 32'(o_Row);
      F_ACT:   return 32'(o_Active);
      F_PIX:   return 32'(o_Pixel);
      F_VAL:   return 32'(o_Pixel_Valid);
      F_LCK:   return 32'(o_Locked);
      F_FS:    return 32'(o_Frame_Start);
      F_TE:    return 32'(o_Timing_Err);
      F_ERR:   return 32'(o_Err_Count);
      default: return 'x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] ob, input logic [31:0] ex);
    n_checks++;
    assert (ob === ex) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, ob, ex);
    end
  endtask

  task automatic want(input string tag, input int f, input int v);
    exp_t e;
    e.tag = tag; e.field = f; e.exp = 32'(v);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.field), e.exp);
    end
  endtask

  function automatic logic hs_ideal();
    return !(sc >= HS_COL && sc < HS_COL + HP);
  endfunction

  function automatic logic vs_ideal();
    return !(sr == VS_ROW);
  endfunction

  // One source sample: drive, clock, score the queued expectations, advance.
  task automatic cyc(input logic hs, input logic vs, input logic [8:0] rgb);
    i_HSync = hs;
    i_VSync = vs;
    {i_Red, i_Grn, i_Blu} = rgb;
    @(posedge i_Clk);
    #1;
    if (o_Frame_Start) fs_cnt++;
    if (o_Timing_Err) te_cnt++;
    drain();
    sc++;
    if (sc == HM) begin
      sc = 0;
      sr = (sr == VM - 1) ? 0 : sr + 1;
    end
  endtask

  task automatic step();
    cyc(hs_ideal(), vs_ideal(), 9'd0);
  endtask

  task automatic ideal_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int c, input int r);
    int guard = 0;
    while (!(sc == c && sr == r) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    if (!(sc == c && sr == r)) begin
      n_checks++;
      n_errors++;
      $error("FAIL run_to: position (%0d,%0d) not reached within %0d cycles", c, r, 2 * FRAME);
    end
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    i_HSync = 1'b1;
    i_VSync = 1'b1;
    @(posedge i_Clk);
    #1;
    drain();
    i_Rst_L = 1'b1;
    sc = 0;
    sr = 0;
  endtask

  initial begin
    i_Rst_L = 1'b0;
    i_HSync = 1'b1;
    i_VSync = 1'b1;
    {i_Red, i_Grn, i_Blu} = 9'd0;

    // Reset state
    want("rst_col", F_COL, 0); want("rst_row", F_ROW, 0);
    want("rst_lock", F_LCK, 0); want("rst_err", F_ERR, 0);
    want("rst_te", F_TE, 0); want("rst_fs", F_FS, 0);
    want("rst_act", F_ACT, 0); want("rst_pix", F_PIX, 0); want("rst_val", F_VAL, 0);
    do_reset();

    // Ideal stream: lock at second vsync fall, one frame start per frame
    run_to(5, 0);
    want("search_act", F_ACT, 0); want("search_col", F_COL, 5);
    step();
    run_to(0, VS_ROW);
    want("fall1_lock", F_LCK, 0);
    step();
    run_to(0, VS_ROW);
    chk("prelock", 32'(o_Locked), 0);
    want("fall2_lock", F_LCK, 1); want("fall2_row", F_ROW, VS_ROW);
    want("fall2_col", F_COL, 0); want("fall2_err", F_ERR, 0);
    step();
    run_to(0, 0);
    want("fs_pulse", F_FS, 1); want("fs_col", F_COL, 0); want("fs_row", F_ROW, 0);
    step();
    want("fs_clear", F_FS, 0);
    step();
    fs_cnt = 0;
    ideal_n(FRAME);
    chk("fs_per_frame", 32'(fs_cnt), 1);
    chk("clean_te", 32'(te_cnt), 0);
    chk("clean_err", 32'(o_Err_Count), 0);

    // Pixel decode and visible-area boundaries
    run_to(5, 0);
    want("pix2_col", F_COL, 5); want("pix2_row", F_ROW, 0); want("pix2_act", F_ACT, 1);
    want("pix2_pix", F_PIX, DEC_EN ? 2 : 0); want("pix2_val", F_VAL, DEC_EN ? 1 : 0);
    cyc(hs_ideal(), vs_ideal(), 9'b111000000);
    want("pixbad_pix", F_PIX, 0); want("pixbad_val", F_VAL, 0);
    cyc(hs_ideal(), vs_ideal(), 9'b000000111);
    want("pix3_pix", F_PIX, DEC_EN ? 3 : 0); want("pix3_val", F_VAL, DEC_EN ? 1 : 0);
    cyc(hs_ideal(), vs_ideal(), 9'b000111000);
    run_to(15, 0);
    want("act_lastcol", F_ACT, 1);
    step();
    want("act_pastcol", F_ACT, 0); want("val_pastcol", F_VAL, 0);
    step();
    run_to(3, 7);
    want("act_lastrow", F_ACT, 1);
    step();
    run_to(3, 8);
    want("act_pastrow", F_ACT, 0);
    step();

    // Hsync fall moved by two columns while locked
    run_to(0, 2);
    te_cnt = 0;
    for (int k = 0; k < HM; k++) begin
      if (sc == HS_COL + 2) begin
        want("shift_te", F_TE, 1); want("shift_err", F_ERR, 1); want("shift_lock", F_LCK, 0);
      end
      if (sc == HS_COL + 3) want("shift_te_end", F_TE, 0);
      cyc(!(sc >= HS_COL + 2 && sc < HS_COL + 2 + HP), vs_ideal(), 9'd0);
    end
    run_to(0, VS_ROW);
    want("shift_fall1_lock", F_LCK, 0);
    step();
    run_to(0, VS_ROW);
    chk("shift_prelock", 32'(o_Locked), 0);
    want("shift_relock", F_LCK, 1);
    step();
    chk("shift_te_once", 32'(te_cnt), 1);
    chk("shift_err_hold", 32'(o_Err_Count), 1);

    // Short hsync pulse while locked
    run_to(0, 2);
    for (int k = 0; k < HM; k++) begin
      if (sc == HS_COL + HP - 2) begin
        want("short_low_te", F_TE, 0); want("short_low_lock", F_LCK, 1);
      end
      if (sc == HS_COL + HP - 1) begin
        want("short_te", F_TE, 1); want("short_err", F_ERR, 2); want("short_lock", F_LCK, 0);
      end
      cyc(!(sc >= HS_COL && sc < HS_COL + HP - 1), vs_ideal(), 9'd0);
    end
    run_to(0, VS_ROW);
    step();
    run_to(0, VS_ROW);
    want("short_relock", F_LCK, 1);
    step();

    // 300 vsync row mismatches, each followed by a fast relock in the same line
    run_to(0, VS_ROW + 1);
    te_cnt = 0;
    for (int ln = 0; ln < 300; ln++) begin
      for (int c = 0; c < HM; c++) begin
        if (ln == 0 && c == 1) begin
          want("sat_first_err", F_ERR, 3); want("sat_first_te", F_TE, 1);
        end
        if (ln == 0 && c == 5) want("sat_relock", F_LCK, 1);
        cyc(hs_ideal(), !(c == 1 || c == 3 || c == 5), 9'd0);
        if (c == 1) sr = VS_ROW;
      end
    end
    chk("sat_err", 32'(o_Err_Count), 255);
    chk("sat_te_count", 32'(te_cnt), 300);
    chk("sat_lock", 32'(o_Locked), 1);

    // Reset mid-frame while locked
    run_to(7, 4);
    chk("pre_reset_lock", 32'(o_Locked), 1);
    want("mid_rst_lock", F_LCK, 0); want("mid_rst_err", F_ERR, 0);
    want("mid_rst_col", F_COL, 0); want("mid_rst_row", F_ROW, 0);
    want("mid_rst_te", F_TE, 0); want("mid_rst_act", F_ACT, 0);
    do_reset();
    want("post_rst_lock", F_LCK, 0); want("post_rst_col", F_COL, 0);
    step();

    // Mismatches ignored while searching, then a fresh lock
    run_to(0, 1);
    te_cnt = 0;
    for (int k = 0; k < HM; k++) begin
      cyc(!(sc >= HS_COL + 2 && sc < HS_COL + 2 + HP), vs_ideal(), 9'd0);
    end
    ideal_n(HM);
    chk("search_te", 32'(te_cnt), 0);
    chk("search_err", 32'(o_Err_Count), 0);
    run_to(0, VS_ROW);
    want("relock_fall1", F_LCK, 0);
    step();
    run_to(0, VS_ROW);
    want("relock_fall2", F_LCK, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  H_ACTIVE, 640, visible columns
  H_FPORCH, 16, horizontal front porch
  H_PULSE, 96, hsync low width in clocks
  H_MAX, 800, clocks per line
  V_ACTIVE, 480, visible rows
  V_FPORCH, 10, vertical front porch
  V_MAX, 525, lines per frame
  LOCK_FRAMES, 2, error-free vsync falls required for lock
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  i_Clk  in  1  single clock, all logic on rising edge
  i_Rst_L  in  1  reset, synchronous, active-low
  i_HSync  in  1  incoming hsync, active-low pulse
  i_VSync  in  1  incoming vsync, active-low pulse
  i_Red, i_Grn, i_Blu  in  3 each  incoming 9-bit colour
  o_Column  out  10  recovered column of the sample presented
  o_Row  out  10  recovered row of the sample presented
  o_Active  out  1  sample lies in visible area (column<H_ACTIVE, row<V_ACTIVE)
  o_Pixel  out  2  decoded sprite pixel code
  o_Pixel_Valid  out  1  o_Pixel is meaningful
  o_Locked  out  1  timing locked
  o_Frame_Start  out  1  one-cycle pulse at row 0, column 0 while locked
  o_Timing_Err  out  1  one-cycle pulse on sync mismatch
  o_Err_Count  out  8  saturating mismatch count

Function
REQ-003 The block SHALL register i_HSync and i_VSync once (hs_q, vs_q); a fall is the cycle with prior sample 1 and current sample 0.
REQ-004 The internal column counter SHALL increment every clock and wrap from H_MAX-1 to 0; on each wrap, the row counter SHALL increment and wrap from V_MAX-1 to 0.
REQ-005 On an hsync fall, the expected column is H_ACTIVE+H_FPORCH (656); the block SHALL load column := 657 on that edge.
REQ-006 On a vsync fall, the expected row is V_ACTIVE+V_FPORCH-1 (489); the block SHALL load row := 489 on that edge, without overriding the REQ-004 column update.
REQ-007 The hsync low width SHALL be counted; a rising edge after a width other than H_PULSE SHALL be a mismatch.
REQ-008 The FSM SHALL have states SEARCH, TRACK and LOCKED. SEARCH->TRACK occurs on the first vsync fall. TRACK->LOCKED occurs after LOCK_FRAMES consecutive vsync falls with no mismatch. In TRACK, a mismatch SHALL clear the good-frame count.
REQ-009 Mismatch rules: in TRACK or LOCKED, an hsync fall at a column other than 656, a vsync fall at a row other than 489, or a bad pulse width (REQ-007) is a mismatch. In SEARCH, mismatches SHALL be ignored.
REQ-010 A mismatch in LOCKED SHALL pulse o_Timing_Err for 1 cycle, increment o_Err_Count (saturating at 255), and move the FSM to TRACK. Counters SHALL still resync per REQ-005/006.
REQ-011 Simultaneous hsync fall and vsync fall SHALL apply both loads in the same cycle; two mismatches in one cycle SHALL count once.
REQ-012 All outputs SHALL be registered with 1-cycle latency. o_Column/o_Row/o_Pixel SHALL describe the colour sampled on the preceding edge.
REQ-013 o_Active SHALL be 0 unless o_Locked=1.
REQ-014 o_Frame_Start SHALL assert only when locked and o_Row=0, o_Column=0.

Reset
REQ-015 When i_Rst_L=0 at a rising edge, the block SHALL set state SEARCH, row=0, column=0, hs_q=vs_q=1, o_Err_Count=0, and all 1-bit outputs and o_Pixel to 0. Reset mid-frame SHALL discard lock immediately.

Configuration
REQ-016 Macro VGA_RX_PIXEL_DECODE_EN SHALL control pixel decoding.
  Defined: while o_Active, the colour SHALL map 9'b000000000->0, 9'b111111100->1, 9'b111000000->2, 9'b000111000->3 with o_Pixel_Valid=1. Any other colour SHALL give o_Pixel=0 and o_Pixel_Valid=0.
  Undefined: o_Pixel and o_Pixel_Valid SHALL be constant 0 and the colour inputs unused.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
  Ideal 640x480 stream from reset, 3 frames -> o_Locked rises at the 2nd vsync fall (+1 cycle), o_Err_Count=0, o_Frame_Start once per 420000 clocks.
  Locked; one hsync fall moved to column 660 -> single o_Timing_Err pulse, o_Err_Count=1, o_Locked=0, relock after 2 clean frames.
  hsync pulse 95 clocks while locked -> mismatch at rising edge, FSM to TRACK.
  Colour 9'b111000000 at row 0, column 5 (macro defined) -> o_Pixel=2, o_Pixel_Valid=1, o_Column=5 one cycle later; 9'b000000111 -> o_Pixel_Valid=0.
  300 injected mismatches -> o_Err_Count holds at 255.
  i_Rst_L low for 1 cycle mid-frame -> next cycle SEARCH, o_Locked=0, o_Err_Count=0.
